acc_uart_streamer: RTL and testbench

Transmit-side counterpart to the UART instruction loader. On command from the control FSM, it reads a run of accumulator words out of the systolic array through its `addr_acc`/`acc_out` read port and serializes them to the host over a UART 8N1 TX line. Each run is sent as one framed byte stream. This block implements the `WRITE_ACC_OUT` path and sits between the control FSM and the board's FTDI TX pin.

---
 rtl/acc_uart_streamer_if.sv | 27 ++
 rtl/acc_uart_streamer.sv | 202 ++++++++++++++++++++
 tb/tb_acc_uart_streamer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/acc_uart_streamer_if.sv
// Control/accumulator-read bundle for acc_uart_streamer.
//   start, start_addr, count : frame request from the control FSM
//   addr_acc / acc_out       : accumulator read port (data one cycle after address)
//   busy, done               : frame status back to the control FSM
// master: control FSM + systolic read port side. slave: the streamer.
interface acc_uart_streamer_if #(
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned ACC_ADDR_WIDTH = 6
);
  logic                      start;
  logic [ACC_ADDR_WIDTH-1:0] start_addr;
  logic [ACC_ADDR_WIDTH:0]   count;
  logic [ACC_ADDR_WIDTH-1:0] addr_acc;
  logic [ACC_WIDTH-1:0]      acc_out;
  logic                      busy;
  logic                      done;

  modport master (
    output start, start_addr, count, acc_out,
    input  addr_acc, busy, done
  );

  modport slave (
    input  start, start_addr, count, acc_out,
    output addr_acc, busy, done
  );
endinterface

// File: rtl/acc_uart_streamer.sv
// Streams a run of accumulator words to the host as one UART 8N1 frame:
// HEADER, then count words, each LSB byte first, with no idle gap between bytes.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of acc_uart_streamer_if (start/start_addr/count in,
//              addr_acc out, acc_out in, busy/done out)
//   uart_tx  : serial output, idle high
module acc_uart_streamer #(
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned MATRIX_SIZE    = 8,
  parameter int unsigned ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
  parameter int unsigned F_CLK          = 50_000_000,
  parameter int unsigned BAUD           = 921_600,
  parameter int unsigned CLK_PER_BIT    = F_CLK / BAUD,
  parameter logic [7:0]  HEADER         = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  acc_uart_streamer_if.slave bus,
  output logic               uart_tx
);

  localparam int unsigned BYTES_PER_WORD = ACC_WIDTH / 8;
  localparam int unsigned DEPTH          = MATRIX_SIZE * MATRIX_SIZE;
  localparam int unsigned AW             = ACC_ADDR_WIDTH;
  localparam int unsigned CNTW           = ACC_ADDR_WIDTH + 1;
  localparam int unsigned CW             = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int unsigned BW             = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [8:0]           sh_q, sh_d;        // {stop, data} still to go out
  logic [3:0]           bit_q, bit_d;      // bit on the wire: 0 start .. 9 stop
  logic [CW-1:0]        clk_q, clk_d;      // cycle within current bit
  logic [ACC_WIDTH-1:0] cur_q, cur_d;      // remaining bytes of word on the wire
  logic [BW-1:0]        left_q, left_d;    // bytes of cur_q not yet started
  logic [ACC_WIDTH-1:0] pre_q, pre_d;      // prefetched next word
  logic                 pre_vld_q, pre_vld_d;
  logic [CNTW-1:0]      fetch_q, fetch_d;  // fetches still to issue
  logic                 hdr_q, hdr_d;      // header is the byte on the wire

  logic                 load_byte;
  logic [7:0]           byte_nxt;
  logic [CNTW-1:0]      cnt_eff;
  logic [AW-1:0]        addr_inc;

  // Zero and oversize counts both mean a full-array dump.
  always_comb begin
    cnt_eff = bus.count;
    if (bus.count == '0 || bus.count > CNTW'(DEPTH)) begin
      cnt_eff = CNTW'(DEPTH);
    end
  end

  assign addr_inc = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      sh_q      <= '1;
      bit_q     <= '0;
      clk_q     <= '0;
      cur_q     <= '0;
      left_q    <= '0;
      pre_q     <= '0;
      pre_vld_q <= 1'b0;
      fetch_q   <= '0;
      hdr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      clk_q     <= clk_d;
      cur_q     <= cur_d;
      left_q    <= left_d;
      pre_q     <= pre_d;
      pre_vld_q <= pre_vld_d;
      fetch_q   <= fetch_d;
      hdr_q     <= hdr_d;
    end
  end

  // Next-state: fetch sequencing plus bit/byte timing of the TX shifter.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    clk_d     = clk_q;
    cur_d     = cur_q;
    left_d    = left_q;
    pre_d     = pre_q;
    pre_vld_d = pre_vld_q;
    fetch_d   = fetch_q;
    hdr_d     = hdr_q;
    load_byte = 1'b0;
    byte_nxt  = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_byte = 1'b1;
          byte_nxt  = HEADER;
          busy_d    = 1'b1;
          addr_d    = bus.start_addr;
          fetch_d   = cnt_eff - CNTW'(1);
          left_d    = '0;
          pre_vld_d = 1'b0;
          hdr_d     = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        pre_d     = bus.acc_out;
        pre_vld_d = 1'b1;
        state_d   = hdr_q ? S_HDR : S_SEND;
      end
      S_HDR, S_SEND: ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // A byte is >= 20 cycles, so its end never overlaps FETCH/CAPTURE.
    if (state_q != S_IDLE && state_q != S_DONE) begin
      if (clk_q == CW'(CLK_PER_BIT - 1)) begin
        clk_d = '0;
        if (bit_q == 4'd9) begin
          if (left_q != '0) begin
            load_byte = 1'b1;
            byte_nxt  = cur_q[7:0];
            cur_d     = cur_q >> 8;
            left_d    = left_q - BW'(1);
          end else if (pre_vld_q) begin
            // Promote the prefetched word and start fetching the one after it.
            load_byte = 1'b1;
            byte_nxt  = pre_q[7:0];
            cur_d     = pre_q >> 8;
            left_d    = BW'(BYTES_PER_WORD - 1);
            pre_vld_d = 1'b0;
            hdr_d     = 1'b0;
            if (fetch_q != '0) begin
              fetch_d = fetch_q - CNTW'(1);
              addr_d  = addr_inc;
              state_d = S_FETCH;
            end else begin
              state_d = S_SEND;
            end
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end else begin
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
          bit_d = bit_q + 4'd1;
        end
      end else begin
        clk_d = clk_q + CW'(1);
      end
    end

    if (load_byte) begin
      tx_d  = 1'b0;
      sh_d  = {1'b1, byte_nxt};
      bit_d = '0;
      clk_d = '0;
    end
  end

  assign uart_tx      = tx_q;
  assign bus.addr_acc = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_acc_uart_streamer.sv
// Scoreboard bench for acc_uart_streamer: stimulus pushes expected bytes,
// a UART line monitor decodes uart_tx and pops/compares each byte.
module tb_acc_uart_streamer;
  localparam int unsigned C     = 4;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  logic uart_tx;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   t0 = 0;

  logic [31:0] mem [DEPTH];
  logic [7:0]  exp_q[$];
  int          addr_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acc_uart_streamer_if #(.ACC_WIDTH(32), .ACC_ADDR_WIDTH(AW)) bus();

  acc_uart_streamer #(
    .ACC_WIDTH(32), .MATRIX_SIZE(8), .CLK_PER_BIT(C), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx)
  );

  // Accumulator read port: data one cycle after address.
  always @(posedge clk) bus.acc_out <= mem[bus.addr_acc];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Address trace while busy.
  always @(negedge clk) begin
    if (bus.busy === 1'b1 && (addr_log.size() == 0 || int'(bus.addr_acc) != addr_log[$]))
      addr_log.push_back(int'(bus.addr_acc));
  end

  // UART monitor: decode bytes, check stop bit, inter-byte spacing, scoreboard.
  bit         mon_act = 0;
  bit         in_frame = 0;
  int         mon_cnt = 0;
  int         prev_start = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] want;
  always @(negedge clk) begin
    if (rst) begin
      mon_act  = 0;
      in_frame = 0;
    end else begin
      if (!mon_act) begin
        if (uart_tx === 1'b0) begin
          mon_act = 1;
          mon_cnt = 0;
          if (in_frame) check("byte_gap", 32'(cyc - prev_start), 32'(10 * C));
          in_frame   = 1;
          prev_start = cyc;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % C == C / 2) begin
          if (mon_cnt / C >= 1 && mon_cnt / C <= 8) begin
            mon_byte[mon_cnt / C - 1] = uart_tx;
          end else if (mon_cnt / C == 9) begin
            check("stop_bit", 32'(uart_tx), 32'd1);
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_byte: got %0h expected none", mon_byte);
            end else begin
              want = exp_q.pop_front();
              check("byte", 32'(mon_byte), 32'(want));
            end
            mon_act = 0;
          end
        end
      end
      if (bus.busy !== 1'b1 && !mon_act) in_frame = 0;
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic issue_start(input int addr, input int n);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = AW'(addr);
    bus.count      = (AW + 1)'(n);
    addr_log.delete();
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_bit", 32'(uart_tx), 32'd0);
  endtask

  task automatic wait_done(input int nbytes, input bit pulse_mid, input bit rearm);
    int busy_cyc = 0;
    int off      = cyc - t0;
    bit got      = 0;
    for (int i = 0; i < nbytes * 10 * C + 20; i++) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin
        got = 1;
        break;
      end
      if (pulse_mid) bus.start = (i == 37);
      @(negedge clk);
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("done_time", 32'(cyc - t0), 32'(nbytes * 10 * C));
      check("done_busy", 32'(bus.busy), 32'd0);
      check("done_tx", 32'(uart_tx), 32'd1);
      check("busy_cycles", 32'(busy_cyc), 32'(nbytes * 10 * C - off));
    end
    if (rearm) begin
      bus.start = 1'b1;
      @(negedge clk);
      addr_log.delete();
      check("start_in_done_ignored", 32'(bus.busy), 32'd0);
      check("done_pulse", 32'(bus.done), 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      t0 = cyc;
      check("rearm_busy", 32'(bus.busy), 32'd1);
      check("rearm_start_bit", 32'(uart_tx), 32'd0);
    end else begin
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'd0);
    end
  endtask

  task automatic check_addrs(input int a0, input int n);
    check("addr_count", 32'(addr_log.size()), 32'(n));
    for (int k = 0; k < n && k < addr_log.size(); k++)
      check("addr_seq", 32'(addr_log[k]), 32'((a0 + k) % DEPTH));
  endtask

  int dn;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_addr", 32'(bus.addr_acc), 32'd0);
    rst = 1'b0;

    // Single word: A5 78 56 34 12
    mem[5] = 32'h12345678;
    exp_q.push_back(8'hA5); push_word(32'h12345678);
    issue_start(5, 1);
    wait_done(5, 1'b0, 1'b0);
    check_addrs(5, 1);

    // Address wrap 62, 63, 0
    mem[62] = 32'h11; mem[63] = 32'h22; mem[0] = 32'h33; mem[1] = 32'h44;
    exp_q.push_back(8'hA5); push_word(32'h11); push_word(32'h22); push_word(32'h33);
    issue_start(62, 3);
    wait_done(13, 1'b0, 1'b0);
    check_addrs(62, 3);

    // Ignored starts mid-frame and in done cycle, then re-arm at done+1
    exp_q.push_back(8'hA5); push_word(32'h12345678);
    issue_start(5, 1);
    bus.start_addr = AW'(0);
    bus.count      = 7'd2;
    exp_q.push_back(8'hA5); push_word(32'h33); push_word(32'h44);
    wait_done(5, 1'b1, 1'b1);
    wait_done(9, 1'b0, 1'b0);
    check_addrs(0, 2);

    // Reset during byte 2, then a clean frame
    mem[20] = 32'hCAFEF00D; mem[21] = 32'h01020304;
    exp_q.push_back(8'hA5); push_word(32'hCAFEF00D); push_word(32'h01020304);
    issue_start(20, 2);
    repeat (2 * 10 * C + 5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    dn = 0;
    @(negedge clk);
    check("midrst_tx", 32'(uart_tx), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done === 1'b1) dn++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(dn), 32'd0);
    exp_q.push_back(8'hA5); push_word(32'h11); push_word(32'h22);
    issue_start(62, 2);
    wait_done(9, 1'b0, 1'b0);

    // Captured word unaffected by later acc_out change
    mem[9] = 32'hDEADBEEF;
    exp_q.push_back(8'hA5); push_word(32'hDEADBEEF);
    issue_start(9, 1);
    repeat (3) @(negedge clk);
    mem[9] = 32'hFFFFFFFF;
    wait_done(5, 1'b0, 1'b0);

    // Full dump (count=0) and clamped count (100)
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA0B0C0D0 ^ (32'(i) * 32'h01030507);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < DEPTH; k++) push_word(mem[(7 + k) % DEPTH]);
    issue_start(7, 0);
    wait_done(257, 1'b0, 1'b0);
    check_addrs(7, 64);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < DEPTH; k++) push_word(mem[(40 + k) % DEPTH]);
    issue_start(40, 100);
    wait_done(257, 1'b0, 1'b0);
    check_addrs(40, 64);

    repeat (20) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
